// File: rtl/space_invaders_pkg.sv
// Shared types for the space invaders game logic.
// Ship movement FSM states, button directions and playfield limits.
package space_invaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_HOLD,
    ST_REPEAT
  } move_state_e;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } move_dir_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LEFT,
    REQ_RIGHT
  } move_req_e;

  localparam logic [4:0] X_MAX_DEF = 5'd27;

  function automatic move_req_e decode_req(
    input logic l,
    input logic r
  );
    move_req_e req;
    req = REQ_NONE;
    unique case (1'b1)
      (l & ~r): req = REQ_LEFT;
      (r & ~l): req = REQ_RIGHT;
      default:  req = REQ_NONE;
    endcase
    return req;
  endfunction

  function automatic move_dir_e req_dir(
    input move_req_e req
  );
    return (req == REQ_RIGHT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/ship_move_ctrl_if.sv
// Signal bundle between the ship movement controller and its
// surroundings (frame timing, buttons, ship datapath).
interface ship_move_ctrl_if;
  import space_invaders_pkg::*;

  logic       i_frame_tick;
  logic       i_game_active;
  logic       i_left_debounced;
  logic       i_right_debounced;
  logic [4:0] i_ship_x;
  logic       o_move_left;
  logic       o_move_right;
  logic       o_repeating;

  modport master (
    output i_frame_tick,
    output i_game_active,
    output i_left_debounced,
    output i_right_debounced,
    output i_ship_x,
    input  o_move_left,
    input  o_move_right,
    input  o_repeating
  );

  modport slave (
    input  i_frame_tick,
    input  i_game_active,
    input  i_left_debounced,
    input  i_right_debounced,
    input  i_ship_x,
    output o_move_left,
    output o_move_right,
    output o_repeating
  );

endinterface

// File: rtl/move_repeat_timer.sv
// Loadable 4-bit frame down-counter for button auto-repeat.
// Clear wins over load, load wins over decrement.
module move_repeat_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/ship_move_ctrl.sv
// Ship movement controller: one move per press, then auto-repeat
// after a hold delay, clipped at the playfield edges.
module ship_move_ctrl
  import space_invaders_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES   = 8,
  parameter int unsigned REPEAT_FRAMES = 2,
  parameter logic [4:0]  X_MAX         = X_MAX_DEF
) (
  input logic             i_clk_25MHz,
  input logic             i_reset_n,
  ship_move_ctrl_if.slave bus
);

  localparam logic [3:0] HOLD_LD = 4'(HOLD_FRAMES - 1);
  localparam logic [3:0] REP_LD  = 4'(REPEAT_FRAMES - 1);

  move_state_e state_q;
  move_state_e state_d;
  move_dir_e   dir_q;
  move_dir_e   dir_d;
  logic        left_q;
  logic        left_d;
  logic        right_q;
  logic        right_d;

  move_req_e   req;
  move_dir_e   rdir;
  logic        fire;
  logic        t_clr;
  logic        t_load;
  logic [3:0]  t_val;
  logic        t_dec;
  logic        t_zero;

  move_repeat_timer u_timer (
    .clk       (i_clk_25MHz),
    .rst_n     (i_reset_n),
    .clr_i     (t_clr),
    .load_i    (t_load),
    .load_val_i(t_val),
    .dec_i     (t_dec),
    .zero_o    (t_zero)
  );

  assign req  = decode_req(bus.i_left_debounced,
                           bus.i_right_debounced);
  assign rdir = req_dir(req);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fire    = 1'b0;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_val   = HOLD_LD;
    t_dec   = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req != REQ_NONE) begin
          state_d = ST_FIRST;
          dir_d   = rdir;
          t_clr   = 1'b1;
        end
      end
      ST_FIRST: begin
        if (bus.i_frame_tick) begin
          fire    = 1'b1;
          t_load  = 1'b1;
          t_val   = HOLD_LD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.i_frame_tick) begin
          if (t_zero) begin
            fire    = 1'b1;
            t_load  = 1'b1;
            t_val   = REP_LD;
            state_d = ST_REPEAT;
          end else begin
            t_dec = 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (bus.i_frame_tick) begin
          if (t_zero) begin
            fire   = 1'b1;
            t_load = 1'b1;
            t_val  = REP_LD;
          end else begin
            t_dec = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Release or reversal preempts any tick-driven action this cycle
    if (state_q != ST_IDLE) begin
      if (req == REQ_NONE) begin
        state_d = ST_IDLE;
        fire    = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
      end else if (rdir != dir_q) begin
        state_d = ST_FIRST;
        dir_d   = rdir;
        fire    = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        t_clr   = 1'b1;
      end
    end

    if (!bus.i_game_active) begin
      state_d = ST_IDLE;
      dir_d   = dir_q;
      fire    = 1'b0;
      t_clr   = 1'b0;
      t_load  = 1'b0;
      t_dec   = 1'b0;
    end

    if (fire) begin
      left_d  = (dir_q == DIR_LEFT) &&
                (bus.i_ship_x != 5'd0);
      right_d = (dir_q == DIR_RIGHT) &&
                (bus.i_ship_x < X_MAX);
    end
  end

  always_ff @(posedge i_clk_25MHz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_LEFT;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign bus.o_move_left  = left_q;
  assign bus.o_move_right = right_q;
  assign bus.o_repeating  = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_ship_move_ctrl.sv
// Self-checking bench for ship_move_ctrl: tick-count reference
// model compared every cycle plus literal scenario expectations.
module tb_ship_move_ctrl;

  localparam int HOLD = 8;
  localparam int REP  = 2;
  localparam int XMAX = 27;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ship_move_ctrl_if bus();

  ship_move_ctrl #(
    .HOLD_FRAMES  (HOLD),
    .REPEAT_FRAMES(REP),
    .X_MAX        (5'd27)
  ) dut (
    .i_clk_25MHz(clk),
    .i_reset_n  (rst_n),
    .bus        (bus)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a press is a run of ticks in one direction;
  // move on tick 1, tick HOLD+1, then every REP ticks after that.
  bit m_press = 0;
  int m_dir   = 0;
  int m_k     = 0;
  int m_req   = 0;
  bit exp_l   = 0;
  bit exp_r   = 0;
  bit exp_rep;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_press = 0;
      m_dir   = 0;
      m_k     = 0;
      exp_l   = 0;
      exp_r   = 0;
    end else begin
      exp_l = 0;
      exp_r = 0;
      m_req = 0;
      if (bus.i_left_debounced && !bus.i_right_debounced)
        m_req = 1;
      if (bus.i_right_debounced && !bus.i_left_debounced)
        m_req = 2;
      if (!bus.i_game_active) begin
        m_press = 0;
      end else if (!m_press) begin
        if (m_req != 0) begin
          m_press = 1;
          m_dir   = m_req;
          m_k     = 0;
        end
      end else if (m_req == 0) begin
        m_press = 0;
      end else if (m_req != m_dir) begin
        m_dir = m_req;
        m_k   = 0;
      end else if (bus.i_frame_tick) begin
        m_k++;
        if (m_k == 1 ||
            (m_k > HOLD && (m_k - 1 - HOLD) % REP == 0)) begin
          if (m_dir == 1 && int'(bus.i_ship_x) != 0)
            exp_l = 1;
          if (m_dir == 2 && int'(bus.i_ship_x) < XMAX)
            exp_r = 1;
        end
      end
    end
  end

  assign exp_rep = m_press && (m_k >= HOLD + 1);

  int frame_no  = 0;
  int rep_first = -1;
  int lq[$];
  int rq[$];

  always @(negedge clk) begin
    check("move_left", int'(bus.o_move_left), int'(exp_l));
    check("move_right", int'(bus.o_move_right), int'(exp_r));
    check("repeating", int'(bus.o_repeating), int'(exp_rep));
    check("not_both",
          int'(bus.o_move_left && bus.o_move_right), 0);
    if (bus.o_move_left)  lq.push_back(frame_no);
    if (bus.o_move_right) rq.push_back(frame_no);
    if (bus.o_repeating && rep_first < 0) rep_first = frame_no;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    lq.delete();
    rq.delete();
    frame_no  = 0;
    rep_first = -1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) step();
      bus.i_frame_tick = 1'b1;
      frame_no++;
      step();
      bus.i_frame_tick = 1'b0;
    end
  endtask

  initial begin
    bus.i_frame_tick      = 1'b0;
    bus.i_game_active     = 1'b0;
    bus.i_left_debounced  = 1'b0;
    bus.i_right_debounced = 1'b0;
    bus.i_ship_x          = 5'd0;
    #1 rst_n = 1'b0;
    bus.i_game_active    = 1'b1;
    bus.i_left_debounced = 1'b1;
    bus.i_ship_x         = 5'd10;
    repeat (3) step();
    check("rst_left", int'(bus.o_move_left), 0);
    check("rst_right", int'(bus.o_move_right), 0);
    check("rst_rep", int'(bus.o_repeating), 0);

    // Held through reset release counts as a fresh press
    rst_n = 1'b1;
    clear_logs();
    frames(20);
    check("left_cnt", lq.size(), 7);
    if (lq.size() == 7) begin
      check("left_f1", lq[0], 1);
      check("left_f9", lq[1], 9);
      check("left_f11", lq[2], 11);
      check("left_f13", lq[3], 13);
      check("left_f15", lq[4], 15);
      check("left_f17", lq[5], 17);
      check("left_f19", lq[6], 19);
    end
    check("rep_from", rep_first, 9);
    check("right_none", rq.size(), 0);

    check("rep_before_stop", int'(bus.o_repeating), 1);
    bus.i_game_active = 1'b0;
    step();
    check("rep_after_stop", int'(bus.o_repeating), 0);
    clear_logs();
    frames(3);
    check("inactive_cnt", lq.size() + rq.size(), 0);

    bus.i_game_active     = 1'b1;
    bus.i_right_debounced = 1'b1;
    clear_logs();
    frames(10);
    check("both_cnt", lq.size() + rq.size(), 0);
    check("both_rep", rep_first, -1);

    bus.i_left_debounced = 1'b0;
    bus.i_ship_x         = 5'd27;
    clear_logs();
    frames(12);
    check("xmax_cnt", rq.size(), 0);
    check("xmax_rep", rep_first, 9);

    bus.i_ship_x          = 5'd10;
    bus.i_right_debounced = 1'b0;
    bus.i_left_debounced  = 1'b1;
    step();
    clear_logs();
    frames(5);
    check("sw_left_cnt", lq.size(), 1);
    if (lq.size() == 1) check("sw_left_f1", lq[0], 1);
    bus.i_left_debounced  = 1'b0;
    bus.i_right_debounced = 1'b1;
    frames(10);
    check("sw_right_cnt", rq.size(), 2);
    if (rq.size() == 2) begin
      check("sw_right_f6", rq[0], 6);
      check("sw_right_f14", rq[1], 14);
    end
    check("sw_left_after", lq.size(), 1);

    check("rep_before_rst", int'(bus.o_repeating), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_left", int'(bus.o_move_left), 0);
    check("async_right", int'(bus.o_move_right), 0);
    check("async_rep", int'(bus.o_repeating), 0);
    #5 rst_n = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
